// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one outstanding request, granted then answered by rvalid.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns core accesses onto a word bus, extends load data,
// and aborts with an error on misalignment, illegal size, bus error or timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       write_q;
  logic       unsigned_q;
  logic [1:0] size_q;
  logic [1:0] lo_q;

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic [1:0] lo,
                                           input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  assign stall = (req_valid && state == S_IDLE) || state == S_REQ || state == S_WAIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      write_q       <= 1'b0;
      unsigned_q    <= 1'b0;
      size_q        <= 2'b00;
      lo_q          <= 2'b00;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'd0;
      bus.bus_wdata <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q       <= req_write;
            unsigned_q    <= req_unsigned;
            size_q        <= req_size;
            lo_q          <= req_addr[1:0];
            cnt           <= 8'd0;
            req_ready     <= 1'b0;
            resp_rdata    <= 32'd0;
            bus.bus_we    <= req_write;
            bus.bus_addr  <= {req_addr[31:2], 2'b00};
            bus.bus_be    <= lane_be(req_size, req_addr[1:0]);
            bus.bus_wdata <= lane_wdata(req_size, req_wdata);
            if (bad_access(req_size, req_addr[1:0])) begin
              state      <= S_RESP;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
            end else begin
              state       <= S_REQ;
              resp_err    <= 1'b0;
              bus.bus_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + 8'd1;
          // The budget is exhausted on this cycle, so a grant arriving now would overrun it.
          if (cnt == LAST_CNT) begin
            state       <= S_RESP;
            bus.bus_req <= 1'b0;
            resp_err    <= 1'b1;
            resp_valid  <= 1'b1;
          end else if (bus.bus_gnt) begin
            state       <= S_WAIT;
            bus.bus_req <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (bus.bus_rvalid) begin
            state      <= S_RESP;
            resp_err   <= bus.bus_err;
            resp_rdata <= (write_q || bus.bus_err) ? 32'd0
                          : load_fmt(size_q, lo_q, unsigned_q, bus.bus_rdata);
            resp_valid <= 1'b1;
          end else if (cnt == LAST_CNT) begin
            state      <= S_RESP;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec scenarios plus randomized traffic
// against a byte-lane reference model with a scripted bus responder.
module tb_load_store_unit;
  localparam int T = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .stall        (stall),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          obs_lat;
  int          obs_reqcyc;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic        obs_we;

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic m_bad(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int m;
    m = ((1 << nbytes(sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] o;
    o = 32'd0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    longint unsigned v, mask;
    int nb;
    nb   = nbytes(sz);
    v    = 64'(rd) >> (8 * (a % 4));
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (!uns && (((v >> (8 * nb - 1)) & 64'd1) != 0)) v = v | ~mask;
    return v[31:0];
  endfunction

  // Runs one access starting at the current negedge (unit idle); g = REQ cycles withheld
  // before gnt, r = WAIT cycles before rvalid, dual = also pulse rvalid alongside gnt.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns, input int g, input int r,
                         input logic [31:0] rd, input logic berr, input logic dual);
    logic        is_bad, exp_err, exp_bus_req, exp_stall, exp_ready, exp_rv, seen_req;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          lat, req_end, last_c, reqs_seen, waits_seen;
    bit          granted;
    is_bad    = m_bad(addr, sz);
    exp_addr  = addr & ~32'd3;
    exp_be    = m_be(addr, sz);
    exp_wdata = m_wdata(wd, sz);
    if (is_bad) begin
      lat = 1; exp_err = 1'b1; exp_rdata = 32'd0; req_end = 0;
    end else if (g + 1 >= T || g + r + 2 > T) begin
      lat = T + 1; exp_err = 1'b1; exp_rdata = 32'd0;
      req_end = (g + 1 < T) ? g + 1 : T;
    end else begin
      lat = g + r + 3; exp_err = berr;
      exp_rdata = (wr || berr) ? 32'd0 : m_load(rd, addr, sz, uns);
      req_end = g + 1;
    end
    last_c = lat + 1;
    if (!is_bad && g + r + 3 > last_c) last_c = g + r + 3;
    if (last_c > 3 * T) last_c = 3 * T;
    obs_lat = -1; obs_reqcyc = 0; obs_rdata = 32'hDEAD_BEEF; obs_err = 1'bx;
    obs_addr = 32'd0; obs_be = 4'd0; obs_wdata = 32'd0; obs_we = 1'b0;

    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL accept_stall: got %b want 1", stall);
    end
    granted = 0; reqs_seen = 0; waits_seen = 0;

    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      exp_bus_req = (c <= req_end);
      exp_rv      = (c == lat);
      exp_stall   = (c < lat);
      exp_ready   = (c > lat);
      seen_req    = bus_if.bus_req;
      total++;
      if (bus_if.bus_req !== exp_bus_req) begin
        bad++; $display("FAIL bus_req cyc%0d: got %b want %b", c, bus_if.bus_req, exp_bus_req);
      end
      total++;
      if (resp_valid !== exp_rv) begin
        bad++; $display("FAIL resp_valid cyc%0d: got %b want %b", c, resp_valid, exp_rv);
      end
      total++;
      if (stall !== exp_stall) begin
        bad++; $display("FAIL stall cyc%0d: got %b want %b", c, stall, exp_stall);
      end
      total++;
      if (req_ready !== exp_ready) begin
        bad++; $display("FAIL req_ready cyc%0d: got %b want %b", c, req_ready, exp_ready);
      end
      if (seen_req === 1'b1) begin
        obs_reqcyc++;
        obs_addr = bus_if.bus_addr; obs_be = bus_if.bus_be;
        obs_wdata = bus_if.bus_wdata; obs_we = bus_if.bus_we;
        total++;
        if ({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata} !==
            {wr, exp_addr, exp_be, exp_wdata}) begin
          bad++;
          $display("FAIL bus_fields cyc%0d: got we=%b a=%h be=%b wd=%h want we=%b a=%h be=%b wd=%h",
                   c, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata,
                   wr, exp_addr, exp_be, exp_wdata);
        end
      end
      if (resp_valid === 1'b1) begin
        obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err;
      end
      if (exp_rv) begin
        total++;
        if ({resp_err, resp_rdata} !== {exp_err, exp_rdata}) begin
          bad++;
          $display("FAIL resp_data: got err=%b rdata=%h want err=%b rdata=%h",
                   resp_err, resp_rdata, exp_err, exp_rdata);
        end
      end
      req_valid = 1'b0;
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
      bus_if.bus_rdata = $urandom;
      if (granted) begin
        if (waits_seen == r) begin
          bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = rd; bus_if.bus_err = berr;
        end
        waits_seen++;
      end else if (seen_req === 1'b1) begin
        if (reqs_seen == g) begin
          bus_if.bus_gnt = 1'b1; granted = 1;
          if (dual) begin
            bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = ~rd; bus_if.bus_err = 1'b1;
          end
        end
        reqs_seen++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'd0; req_unsigned = 1'b0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0; bus_if.bus_err = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, stall, resp_rdata} !== {4'b1000, 32'd0}) begin
      bad++; $display("FAIL reset_core: got rdy=%b rv=%b err=%b stall=%b rdata=%h want 1,0,0,0,0",
                      req_ready, resp_valid, resp_err, stall, resp_rdata);
    end
    total++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata} !== 70'd0) begin
      bad++; $display("FAIL reset_bus: got req=%b we=%b a=%h be=%b wd=%h want all 0",
                      bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    run_txn(1'b0, 32'h0000_1003, $urandom, 2'd0, 1'b0, 0, 0, 32'h80FF_FFFF, 1'b0, 1'b0);
    total++;
    if (obs_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
    total++;
    if (obs_be !== 4'b1000) begin bad++; $display("FAIL lb_be: got %b want 1000", obs_be); end
    total++;
    if (obs_addr !== 32'h0000_1000) begin bad++; $display("FAIL lb_addr: got %h want 00001000", obs_addr); end
    total++;
    if (obs_lat !== 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", obs_lat); end
  endtask

  task automatic test_store_half();
    run_txn(1'b1, 32'h0000_2002, 32'h0000_ABCD, 2'd1, 1'b0, 0, 0, $urandom, 1'b0, 1'b0);
    total++;
    if ({obs_we, obs_be} !== 5'b1_1100) begin bad++; $display("FAIL sh_we_be: got we=%b be=%b want 1 1100", obs_we, obs_be); end
    total++;
    if (obs_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); end
    total++;
    if ({obs_err, obs_rdata} !== 33'd0) begin bad++; $display("FAIL sh_resp: got err=%b rdata=%h want 0 0", obs_err, obs_rdata); end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 32'h0000_3001, $urandom, 2'd2, 1'b0, 0, 0, $urandom, 1'b0, 1'b0);
    total++;
    if ({obs_err, obs_lat, obs_reqcyc} !== {1'b1, 32'd1, 32'd0}) begin
      bad++; $display("FAIL lw_misaligned: got err=%b lat=%0d reqcyc=%0d want 1 1 0", obs_err, obs_lat, obs_reqcyc);
    end
    run_txn(1'b1, 32'h0000_3000, $urandom, 2'd3, 1'b0, 0, 0, $urandom, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_3005, $urandom, 2'd1, 1'b1, 0, 0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_bus_error();
    run_txn(1'b0, 32'h0000_4000, $urandom, 2'd1, 1'b1, 5, 0, $urandom, 1'b1, 1'b0);
    total++;
    if ({obs_err, obs_reqcyc, obs_rdata} !== {1'b1, 32'd6, 32'd0}) begin
      bad++; $display("FAIL lhu_buserr: got err=%b reqcyc=%0d rdata=%h want 1 6 0", obs_err, obs_reqcyc, obs_rdata);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h0000_6000, $urandom, 2'd2, 1'b0, 1000, 0, $urandom, 1'b0, 1'b0);
    total++;
    if ({obs_err, obs_lat, obs_reqcyc} !== {1'b1, 32'(T + 1), 32'(T)}) begin
      bad++; $display("FAIL timeout_req: got err=%b lat=%0d reqcyc=%0d want 1 %0d %0d", obs_err, obs_lat, obs_reqcyc, T + 1, T);
    end
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    total++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL late_rvalid: got rv=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    // Grant arriving on the final budget cycle, and an rvalid beyond the budget in WAIT.
    run_txn(1'b0, 32'h0000_6100, $urandom, 2'd2, 1'b0, T - 1, 0, $urandom, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_6200, $urandom, 2'd2, 1'b0, 2, T - 3, $urandom, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_6300, $urandom, 2'd0, 1'b0, 2, T - 4, 32'h0000_00F0, 1'b0, 1'b0);
  endtask

  task automatic test_rvalid_ignored();
    bus_if.bus_rvalid = 1'b1; bus_if.bus_err = 1'b1;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
    total++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL idle_rvalid: got rv=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    run_txn(1'b0, 32'h0000_7002, $urandom, 2'd1, 1'b0, 0, 2, 32'h8001_7FFF, 1'b0, 1'b1);
    run_txn(1'b0, 32'h0000_7001, $urandom, 2'd0, 1'b1, 3, 0, 32'h0000_9900, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      run_txn(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), $urandom_range(0, 4), $urandom,
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_txn(1'(i % 2), 32'h0000_8000 + 32'(4 * i), $urandom, 2'd2, 1'b0, 0, 0, $urandom, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_5000; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL mid_req_entry: got %b want 1", bus_if.bus_req); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus_if.bus_req, req_ready, resp_valid} !== 3'b010) begin
      bad++; $display("FAIL mid_req_reset: got req=%b rdy=%b rv=%b want 0 1 0", bus_if.bus_req, req_ready, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    total++;
    if ({bus_if.bus_req, req_ready, stall} !== 3'b001) begin
      bad++; $display("FAIL mid_wait_entry: got req=%b rdy=%b stall=%b want 0 0 1", bus_if.bus_req, req_ready, stall);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus_if.bus_req, req_ready, stall, resp_valid} !== 4'b0100) begin
      bad++; $display("FAIL mid_wait_reset: got req=%b rdy=%b stall=%b rv=%b want 0 1 0 0",
                      bus_if.bus_req, req_ready, stall, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus_if.bus_rvalid = 1'b0;
      total++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        bad++; $display("FAIL mid_no_resp cyc%0d: got rv=%b rdy=%b want 0 1", c, resp_valid, req_ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_bus_error();
    test_timeout();
    test_rvalid_ignored();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles in REQ+WAIT before an abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 req_valid  input  1  core memory access request (load or store) from EX.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data, right-aligned.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  zero-extend load when 1, sign-extend when 0.
REQ-010 req_ready  output  1  unit can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, illegal size, bus error or timeout; valid with resp_valid.
REQ-014 stall  output  1  core pipeline hold.
REQ-015 bus_req  output  1  bus request.
REQ-016 bus_we  output  1  bus write.
REQ-017 bus_addr  output  32  word-aligned address.
REQ-018 bus_be  output  4  byte enables.
REQ-019 bus_wdata  output  32  lane-replicated store data.
REQ-020 bus_gnt  input  1  request accepted by bus.
REQ-021 bus_rvalid  input  1  response (read data or write ack) valid.
REQ-022 bus_rdata  input  32  read data.
REQ-023 bus_err  input  1  bus error; sampled only with bus_rvalid.

Function
REQ-024 FSM states: IDLE, REQ, WAIT, RESP; all outputs come from registered state and latched request fields.
REQ-025 IDLE: req_ready=1 and bus_req=0. On req_valid, the unit latches all req_* fields.
REQ-026 IDLE, misaligned or illegal request: misaligned is half with addr[0]=1 or word with addr[1:0]!=0; illegal is size 11. The unit goes to RESP with err=1 and makes no bus access.
REQ-027 IDLE, aligned request: the unit goes to REQ.
REQ-028 REQ: bus_req=1, and bus_we/addr/be/wdata stay stable until bus_gnt. On bus_gnt the unit goes to WAIT.
REQ-029 WAIT: on bus_rvalid the unit latches the formatted data and bus_err, then goes to RESP. bus_rvalid is ignored in any other state.
REQ-030 RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in REQ, WAIT and RESP.
REQ-031 Latency with gnt and rvalid each on their first cycle: resp_valid is asserted 3 cycles after acceptance; an error response is asserted 1 cycle after acceptance.
REQ-032 stall = (req_valid in IDLE) or (state != RESP and state != IDLE). stall deasserts in the RESP cycle.
REQ-033 bus_addr = {addr[31:2], 2'b00}.
REQ-034 bus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-035 bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-036 Load data: byte lane is addr[1:0] and half lane is addr[1]. Data is zero- or sign-extended to 32 bits per req_unsigned. Word loads pass through unchanged.
REQ-037 Timeout: an 8-bit counter clears on acceptance and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES the unit goes to RESP with err=1 and drops bus_req. A late rvalid after timeout is ignored.
REQ-038 bus_gnt and bus_rvalid in the same REQ cycle: only gnt is taken; the rvalid is ignored.

Reset
REQ-039 While rst_n=0 the unit is in IDLE with the counter at 0. All outputs are 0 except req_ready, which is 1.
REQ-040 Reset asserted mid-transaction drops bus_req asynchronously and discards the transaction; no resp_valid is produced.

Verification
REQ-041 LB addr 0x1003, signed, rdata 0x80FF_FFFF, gnt/rvalid immediate -> bus_be 1000, bus_addr 0x1000, resp_rdata 0xFFFF_FF80, resp_valid 3 cycles after accept.
REQ-042 SH addr 0x2002, wdata 0x0000_ABCD -> bus_be 1100, bus_wdata 0xABCD_ABCD, bus_we 1, resp_rdata 0.
REQ-043 LW addr 0x3001 -> resp_err=1 one cycle after accept, bus_req never asserted.
REQ-044 LHU addr 0x4000, gnt withheld 5 cycles, then rvalid with bus_err=1 -> bus outputs stable throughout, resp_err=1.
REQ-045 TIMEOUT_CYCLES=4, gnt never given -> bus_req drops and resp_err=1 after 4 cycles; a later rvalid has no effect.
REQ-046 rst_n pulled low in WAIT -> bus_req=0 immediately, req_ready=1, no resp_valid.
